sq_doorbell_sched: RTL and testbench

//  Round-robin scheduler sharing the single SQ producer-index doorbell handshake port of the ERNIC
//  (o_qp_sq_pidb_*) among NUM_REQ WQE posters. Each requester owns one QP.
//  - Keeps each QP's SQ producer index (PI) and outstanding-WQE credit count.
//  - Rings one doorbell per granted request with the updated PI.
//  - Blocks a request that would overflow its SQ.

---
 rtl/sq_doorbell_sched.sv | 186 ++++++++++++++++++
 tb/tb_sq_doorbell_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_doorbell_sched.sv
// Round-robin scheduler sharing one ERNIC SQ producer-index doorbell among NUM_REQ WQE posters.
// Tracks per-QP producer index and outstanding WQEs, and holds back requests that would overflow an SQ.
module sq_doorbell_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SQ_DEPTH  = 16,
    parameter int unsigned CNT_W     = $clog2(SQ_DEPTH) + 1,
    parameter logic [31:0] DB_BASE   = 32'h5004_0338,
    parameter logic [31:0] DB_STRIDE = 32'h0000_0100
) (
    input  logic                     core_clk,
    input  logic                     core_rst,
    input  logic                     conf_of_reg_done,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CNT_W-1:0] req_cnt,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     cmpl_valid,
    input  logic [2:0]               cmpl_qp,
    input  logic [CNT_W-1:0]         cmpl_cnt,
    output logic [15:0]              o_qp_sq_pidb_hndshk,
    output logic [31:0]              o_qp_sq_pidb_wr_addr_hndshk,
    output logic                     o_qp_sq_pidb_wr_valid_hndshk,
    input  logic                     i_qp_sq_pidb_wr_rdy,
    output logic                     o_busy,
    output logic                     o_err_underflow
);
    localparam int unsigned PI_W  = $clog2(SQ_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(SQ_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e             state_q, state_d;
    logic [PI_W-1:0]    pi_q    [NUM_REQ];
    logic [PI_W-1:0]    pi_d    [NUM_REQ];
    logic [CNT_W-1:0]   outst_q [NUM_REQ];
    logic [CNT_W-1:0]   outst_d [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [15:0]        db_data_q, db_data_d;
    logic [31:0]        db_addr_q, db_addr_d;
    logic               db_valid_q, db_valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [PTR_W-1:0]   g_idx;
    logic               grant;
    logic [CNT_W-1:0]   grant_cnt;
    logic [SUM_W-1:0]   pi_sum;
    logic [PI_W-1:0]    pi_new;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // A request acknowledged in the current cycle is still being held by its poster; skip it.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i]  = req_cnt[i*CNT_W +: CNT_W];
            elig[i] = req_valid[i] && !req_ready_q[i] &&
                      (({1'b0, outst_q[i]} + {1'b0, cnt[i]}) <= DEPTH_S);
        end
    end

    always_comb begin
        found = 1'b0;
        g_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            logic [PTR_W-1:0] idx;
            idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                g_idx = idx;
            end
        end
    end

    assign grant     = (state_q == S_IDLE) && conf_of_reg_done && found;
    assign grant_cnt = cnt[g_idx];
    assign pi_sum    = SUM_W'(pi_q[g_idx]) + SUM_W'(grant_cnt);
    assign pi_new    = (pi_sum >= DEPTH_S) ? PI_W'(pi_sum - DEPTH_S) : PI_W'(pi_sum);

    always_ff @(posedge core_clk) begin
        if (core_rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant && grant_cnt != '0) state_d = S_WAIT;
            S_WAIT:  if (i_qp_sq_pidb_wr_rdy)      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default at the top so the combinational block never infers a latch.
    always_comb begin
        req_ready_d = '0;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        db_data_d   = db_data_q;
        db_addr_d   = db_addr_q;
        db_valid_d  = db_valid_q;
        busy_d      = busy_q;
        err_d       = err_q;
        pi_d        = pi_q;
        outst_d     = outst_q;

        if (grant) begin
            req_ready_d[g_idx] = 1'b1;
            gnt_d              = g_idx;
            if (grant_cnt == '0) begin
                rr_ptr_d = ptr_inc(g_idx);
            end else begin
                pi_d[g_idx] = pi_new;
                db_data_d   = 16'(pi_new);
                db_addr_d   = DB_BASE + 32'(g_idx) * DB_STRIDE;
                db_valid_d  = 1'b1;
                busy_d      = 1'b1;
            end
        end

        if (state_q == S_WAIT && i_qp_sq_pidb_wr_rdy) begin
            db_valid_d = 1'b0;
            busy_d     = 1'b0;
            rr_ptr_d   = ptr_inc(gnt_q);
        end

        // Credit add from a grant and credit return from a completion net out in one step.
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [SUM_W-1:0] total;
            logic [SUM_W-1:0] sub;
            total = {1'b0, outst_q[i]} +
                    ((grant && g_idx == PTR_W'(i)) ? {1'b0, grant_cnt} : '0);
            sub   = (cmpl_valid && cmpl_qp == 3'(i)) ? {1'b0, cmpl_cnt} : '0;
            if (sub > total) begin
                outst_d[i] = '0;
                err_d      = 1'b1;
            end else begin
                outst_d[i] = CNT_W'(total - sub);
            end
        end
    end

    // NOTE: pi/outst are small flop arrays rather than RAM, so they clear with the rest of the state.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pi_q[i]    <= '0;
                outst_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            req_ready_q <= '0;
            db_data_q   <= '0;
            db_addr_q   <= '0;
            db_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pi_q        <= pi_d;
            outst_q     <= outst_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            req_ready_q <= req_ready_d;
            db_data_q   <= db_data_d;
            db_addr_q   <= db_addr_d;
            db_valid_q  <= db_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign req_ready                    = req_ready_q;
    assign o_qp_sq_pidb_hndshk          = db_data_q;
    assign o_qp_sq_pidb_wr_addr_hndshk  = db_addr_q;
    assign o_qp_sq_pidb_wr_valid_hndshk = db_valid_q;
    assign o_busy                       = busy_q;
    assign o_err_underflow              = err_q;

endmodule

// File: tb/tb_sq_doorbell_sched.sv
// Self-checking bench for sq_doorbell_sched: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_sq_doorbell_sched;
    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam logic [31:0] BASE = 32'h5004_0338;

    logic          clk = 1'b0;
    logic          core_rst;
    logic          conf_of_reg_done;
    logic [N-1:0]  req_valid;
    logic [N*CW-1:0] req_cnt;
    logic [N-1:0]  req_ready;
    logic          cmpl_valid;
    logic [2:0]    cmpl_qp;
    logic [CW-1:0] cmpl_cnt;
    logic [15:0]   db_data;
    logic [31:0]   db_addr;
    logic          db_valid;
    logic          db_rdy;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    sq_doorbell_sched #(.NUM_REQ(N), .SQ_DEPTH(DEPTH)) dut (
        .core_clk                    (clk),
        .core_rst                    (core_rst),
        .conf_of_reg_done            (conf_of_reg_done),
        .req_valid                   (req_valid),
        .req_cnt                     (req_cnt),
        .req_ready                   (req_ready),
        .cmpl_valid                  (cmpl_valid),
        .cmpl_qp                     (cmpl_qp),
        .cmpl_cnt                    (cmpl_cnt),
        .o_qp_sq_pidb_hndshk         (db_data),
        .o_qp_sq_pidb_wr_addr_hndshk (db_addr),
        .o_qp_sq_pidb_wr_valid_hndshk(db_valid),
        .i_qp_sq_pidb_wr_rdy         (db_rdy),
        .o_busy                      (busy),
        .o_err_underflow             (err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int c);
        req_valid[i]          = 1'b1;
        req_cnt[i*CW +: CW]   = CW'(c);
    endtask

    task automatic clr_req(input int i);
        req_valid[i]        = 1'b0;
        req_cnt[i*CW +: CW] = '0;
    endtask

    typedef struct {
        logic        rst;
        logic        conf;
        logic [3:0]  valid;
        logic [19:0] cnt;
        logic        rdy;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [15:0] e_data;
        logic [31:0] e_addr;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(logic rst, logic conf, logic [3:0] v, logic [19:0] c, logic rdy,
                                logic [3:0] er, logic ev, logic [15:0] ed, logic [31:0] ea,
                                logic eb);
        vec_t r;
        r = '{rst, conf, v, c, rdy, er, ev, ed, ea, eb};
        return r;
    endfunction

    // Reference model state
    int          pi_m [N];
    int          outst_m [N];
    int          rr_m, gnt_m, exp_data, exp_addr;
    bit          busy_m, err_m;
    logic [N-1:0] ack_m, seen;
    bit          pend [N];
    int          pcnt [N];

    initial begin
        vec_t vecs[$];
        core_rst = 1'b1; conf_of_reg_done = 1'b0; req_valid = '0; req_cnt = '0;
        cmpl_valid = 1'b0; cmpl_qp = '0; cmpl_cnt = '0; db_rdy = 1'b0;

        // rst conf valid cnt rdy | ready valid data addr busy
        vecs.push_back(mk(1, 0, 4'h0, 20'd0, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 20'd3, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(0, 1, 4'h1, 20'd3, 1, 4'h1, 1, 16'd3, BASE, 1));
        vecs.push_back(mk(0, 1, 4'h1, 20'd3, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(0, 1, 4'h0, 20'd0, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(1, 1, 4'h0, 20'd0, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h1, 1, 16'd1, BASE, 1));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h2, 1, 16'd1, BASE + 32'h100, 1));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h4, 1, 16'd1, BASE + 32'h200, 1));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h8, 1, 16'd1, BASE + 32'h300, 1));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h1, 1, 16'd2, BASE, 1));
        vecs.push_back(mk(0, 1, 4'hF, {4{5'd1}}, 1, 4'h0, 0, 16'd0, 32'd0, 0));
        vecs.push_back(mk(1, 1, 4'h0, 20'd0, 1, 4'h0, 0, 16'd0, 32'd0, 0));

        tick();
        foreach (vecs[n]) begin
            core_rst = vecs[n].rst; conf_of_reg_done = vecs[n].conf;
            req_valid = vecs[n].valid; req_cnt = vecs[n].cnt; db_rdy = vecs[n].rdy;
            tick();
            check($sformatf("vec%0d ready", n), 32'(req_ready), 32'(vecs[n].e_ready));
            check($sformatf("vec%0d valid", n), 32'(db_valid), 32'(vecs[n].e_valid));
            check($sformatf("vec%0d busy", n), 32'(busy), 32'(vecs[n].e_busy));
            check($sformatf("vec%0d err", n), 32'(err), 32'd0);
            if (vecs[n].e_valid) begin
                check($sformatf("vec%0d data", n), 32'(db_data), 32'(vecs[n].e_data));
                check($sformatf("vec%0d addr", n), db_addr, vecs[n].e_addr);
            end
        end

        // Overflow blocking, conservative completion timing, full-SQ boundary, zero-count grant
        core_rst = 1'b0; conf_of_reg_done = 1'b1; db_rdy = 1'b1; req_valid = '0; req_cnt = '0;
        set_req(1, 10); tick();
        check("A first ready", 32'(req_ready), 32'h2);
        check("A first data", 32'(db_data), 32'd10);
        check("A first addr", db_addr, BASE + 32'h100);
        tick();
        check("A first done", 32'(db_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("A overflow blocked", 32'(req_ready), 32'h0);
        end
        cmpl_valid = 1'b1; cmpl_qp = 3'd1; cmpl_cnt = 5'd4; tick();
        cmpl_valid = 1'b0;
        check("A same-cycle cmpl still blocked", 32'(req_ready), 32'h0);
        tick();
        check("A unblocked ready", 32'(req_ready), 32'h2);
        check("A wrapped pi", 32'(db_data), 32'd4);
        check("A wrapped addr", db_addr, BASE + 32'h100);
        tick();
        check("A second done", 32'(db_valid), 32'd0);
        set_req(1, 1);
        tick(); check("A full sq blocked", 32'(req_ready), 32'h0);
        tick(); check("A full sq blocked2", 32'(req_ready), 32'h0);
        set_req(1, 0); tick();
        check("A zero cnt ready", 32'(req_ready), 32'h2);
        check("A zero cnt no db", 32'(db_valid), 32'd0);
        tick();
        check("A zero cnt no reaccept", 32'(req_ready), 32'h0);
        check("A zero cnt no db2", 32'(db_valid), 32'd0);
        clr_req(1);
        cmpl_valid = 1'b1; cmpl_qp = 3'd1; cmpl_cnt = 5'd16; tick();
        cmpl_valid = 1'b0;
        check("A full drain no err", 32'(err), 32'd0);

        // Doorbell stall: outputs stable, no other grant
        db_rdy = 1'b0;
        set_req(2, 3); set_req(3, 2); tick();
        check("B grant ready", 32'(req_ready), 32'h4);
        check("B grant data", 32'(db_data), 32'd3);
        clr_req(2);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("B stall valid", 32'(db_valid), 32'd1);
            check("B stall data", 32'(db_data), 32'd3);
            check("B stall addr", db_addr, BASE + 32'h200);
            check("B stall busy", 32'(busy), 32'd1);
            check("B stall no grant", 32'(req_ready), 32'h0);
        end
        db_rdy = 1'b1; tick();
        check("B rdy drops valid", 32'(db_valid), 32'd0);
        check("B rdy drops busy", 32'(busy), 32'd0);
        tick();
        check("B next grant ready", 32'(req_ready), 32'h8);
        check("B next grant data", 32'(db_data), 32'd2);
        check("B next grant addr", db_addr, BASE + 32'h300);
        clr_req(3); tick();
        check("B next done", 32'(db_valid), 32'd0);

        // Grant and completion on one QP in the same cycle, then underflow
        set_req(0, 5); tick();
        check("C first data", 32'(db_data), 32'd5);
        tick();
        set_req(0, 2); cmpl_valid = 1'b1; cmpl_qp = 3'd0; cmpl_cnt = 5'd3; tick();
        cmpl_valid = 1'b0;
        check("C merged ready", 32'(req_ready), 32'h1);
        check("C merged data", 32'(db_data), 32'd7);
        check("C merged no err", 32'(err), 32'd0);
        tick();
        set_req(0, 13);
        tick(); check("C outst>=4 blocks 13", 32'(req_ready), 32'h0);
        tick(); check("C outst>=4 blocks 13b", 32'(req_ready), 32'h0);
        clr_req(0); cmpl_valid = 1'b1; cmpl_qp = 3'd0; cmpl_cnt = 5'd9; tick();
        cmpl_valid = 1'b0;
        check("C underflow sticky", 32'(err), 32'd1);
        set_req(0, 16); tick();
        check("C clamped outst grant", 32'(req_ready), 32'h1);
        check("C clamped data", 32'(db_data), 32'd7);
        tick(); clr_req(0);
        check("C err stays", 32'(err), 32'd1);

        // Reset in the middle of a doorbell
        db_rdy = 1'b0; set_req(1, 3); tick();
        check("D in flight", 32'(db_valid), 32'd1);
        core_rst = 1'b1; tick();
        check("D rst valid", 32'(db_valid), 32'd0);
        check("D rst busy", 32'(busy), 32'd0);
        check("D rst err", 32'(err), 32'd0);
        check("D rst ready", 32'(req_ready), 32'h0);
        core_rst = 1'b0; db_rdy = 1'b1; tick();
        check("D post-rst ready", 32'(req_ready), 32'h2);
        check("D post-rst data", 32'(db_data), 32'd3);
        check("D post-rst addr", db_addr, BASE + 32'h100);
        tick(); clr_req(1);

        // Random traffic against the reference model
        core_rst = 1'b1; tick(); core_rst = 1'b0;
        foreach (pi_m[i]) begin pi_m[i] = 0; outst_m[i] = 0; pend[i] = 0; pcnt[i] = 0; end
        rr_m = 0; gnt_m = 0; busy_m = 0; err_m = 0; ack_m = '0; seen = '0;
        exp_data = 0; exp_addr = 0;
        for (int t = 0; t < 3000; t++) begin
            bit found;
            int g;
            for (int i = 0; i < N; i++) begin
                if (seen[i]) pend[i] = 0;
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    pcnt[i] = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
                end
                req_valid[i]        = pend[i];
                req_cnt[i*CW +: CW] = CW'(pcnt[i]);
            end
            seen = ack_m;
            conf_of_reg_done = ($urandom_range(0, 15) != 0);
            db_rdy = $urandom_range(0, 1) == 1;
            cmpl_valid = $urandom_range(0, 2) == 0;
            cmpl_qp = 3'($urandom_range(0, 7));
            if (cmpl_qp < 3'(N) && $urandom_range(0, 31) != 0)
                cmpl_cnt = CW'($urandom_range(0, outst_m[cmpl_qp]));
            else
                cmpl_cnt = CW'($urandom_range(0, 16));

            found = 0; g = 0;
            if (!busy_m && conf_of_reg_done) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (rr_m + k) % N;
                    if (!found && pend[i] && !ack_m[i] && outst_m[i] + pcnt[i] <= DEPTH) begin
                        found = 1; g = i;
                    end
                end
            end
            if (found) begin
                outst_m[g] += pcnt[g];
                if (pcnt[g] == 0) begin
                    rr_m = (g + 1) % N;
                end else begin
                    pi_m[g]  = (pi_m[g] + pcnt[g]) % DEPTH;
                    exp_data = pi_m[g];
                    exp_addr = int'(BASE) + g * 256;
                    busy_m   = 1; gnt_m = g;
                end
            end else if (busy_m && db_rdy) begin
                busy_m = 0; rr_m = (gnt_m + 1) % N;
            end
            if (cmpl_valid && int'(cmpl_qp) < N) begin
                if (int'(cmpl_cnt) > outst_m[cmpl_qp]) begin
                    outst_m[cmpl_qp] = 0; err_m = 1;
                end else begin
                    outst_m[cmpl_qp] -= int'(cmpl_cnt);
                end
            end
            ack_m = '0;
            if (found) ack_m[g] = 1'b1;

            tick();
            check($sformatf("rnd%0d ready", t), 32'(req_ready), 32'(ack_m));
            check($sformatf("rnd%0d valid", t), 32'(db_valid), 32'(busy_m));
            check($sformatf("rnd%0d busy", t), 32'(busy), 32'(busy_m));
            check($sformatf("rnd%0d err", t), 32'(err), 32'(err_m));
            if (busy_m) begin
                check($sformatf("rnd%0d data", t), 32'(db_data), 32'(exp_data));
                check($sformatf("rnd%0d addr", t), db_addr, 32'(exp_addr));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
